// File: rtl/inst_fetch_stage.sv
// IF stage: owns the PC, issues in-order imem reads and queues returned words for ID.
// Optional macro FETCH_PERF_EN adds the fetch_bubble_cnt output.
module inst_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  input  logic        id_allowin,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_bubble_cnt
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] DepthC = (CntW + 1)'(DEPTH);

  typedef enum logic [0:0] {StReset, StFetch} state_e;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [PtrW-1:0]   head_q, head_d, tail_q, tail_d, fill_q, fill_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [CntW-1:0]   pend_q, pend_d;
  logic [CntW-1:0]   drop_q, drop_d;
  logic [31:0]       ent_pc_q [DEPTH];
  logic [31:0]       ent_pc_d [DEPTH];
  logic [31:0]       ent_inst_q [DEPTH];
  logic [31:0]       ent_inst_d [DEPTH];
  logic [DEPTH-1:0]  ent_dv_q, ent_dv_d;

  logic [CntW:0] occ;
  logic          head_alloc;
  logic          alloc;
  logic          pop;
  logic          fill;
  logic          unused_rpc;

  assign unused_rpc = ^redirect_pc[1:0];

  // Pre-pop occupancy gates issue, so a full queue never recycles a slot in the same cycle.
  assign occ        = {1'b0, count_q} + {1'b0, drop_q};
  assign inst_req   = (state_q == StFetch) && (occ < DepthC) && !redirect_valid;
  assign inst_addr  = pc_q;
  assign head_alloc = (count_q != '0);
  assign if_valid   = head_alloc && ent_dv_q[head_q];
  assign if_inst    = head_alloc ? ent_inst_q[head_q] : 32'h0;
  assign if_pc      = head_alloc ? ent_pc_q[head_q] : 32'h0;
  assign alloc      = inst_req && inst_addr_ok;
  assign pop        = if_valid && id_allowin;
  assign fill       = inst_data_ok && (drop_q == '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StReset: state_d = StFetch;
      StFetch: state_d = StFetch;
      default: state_d = StReset;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    fill_d     = fill_q;
    count_d    = count_q;
    pend_d     = pend_q;
    drop_d     = drop_q;
    ent_pc_d   = ent_pc_q;
    ent_inst_d = ent_inst_q;
    ent_dv_d   = ent_dv_q;
    if (redirect_valid) begin
      // Every pending entry becomes a response to discard; a response arriving now is
      // consumed here, either as a pending fill or as an already-dropped word.
      ent_dv_d = '0;
      head_d   = '0;
      tail_d   = '0;
      fill_d   = '0;
      count_d  = '0;
      pend_d   = '0;
      drop_d   = drop_q + pend_q - CntW'(inst_data_ok);
      pc_d     = {redirect_pc[31:2], 2'b00};
    end else begin
      if (pop) begin
        head_d = head_q + PtrW'(1);
      end
      if (alloc) begin
        ent_pc_d[tail_q]   = pc_q;
        ent_inst_d[tail_q] = 32'h0;
        ent_dv_d[tail_q]   = 1'b0;
        tail_d             = tail_q + PtrW'(1);
        pc_d               = pc_q + 32'd4;
      end
      if (inst_data_ok) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CntW'(1);
        end else begin
          ent_inst_d[fill_q] = inst_rdata;
          ent_dv_d[fill_q]   = 1'b1;
          fill_d             = fill_q + PtrW'(1);
        end
      end
      count_d = count_q + CntW'(alloc) - CntW'(pop);
      pend_d  = pend_q + CntW'(alloc) - CntW'(fill);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StReset;
      pc_q       <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      count_q    <= '0;
      pend_q     <= '0;
      drop_q     <= '0;
      ent_pc_q   <= '{default: '0};
      ent_inst_q <= '{default: '0};
      ent_dv_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      fill_q     <= fill_d;
      count_q    <= count_d;
      pend_q     <= pend_d;
      drop_q     <= drop_d;
      ent_pc_q   <= ent_pc_d;
      ent_inst_q <= ent_inst_d;
      ent_dv_q   <= ent_dv_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] bubble_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_q <= 32'h0;
    end else if ((state_q == StFetch) && id_allowin && !if_valid && !redirect_valid) begin
      bubble_q <= bubble_q + 32'd1;
    end
  end

  assign fetch_bubble_cnt = bubble_q;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(inst_data_ok && (pend_q == '0) && (drop_q == '0)));
      assert (occ <= DepthC);
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Testbench for inst_fetch_stage with an in-order imem of configurable latency.
module tb_inst_fetch_stage;

  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok = 1'b0;
  logic        inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = 32'h0;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        id_allowin = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_bubble_cnt;
`endif

  always #5 clk = ~clk;

  inst_fetch_stage #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .inst_req       (inst_req),
    .inst_addr      (inst_addr),
    .inst_addr_ok   (inst_addr_ok),
    .inst_data_ok   (inst_data_ok),
    .inst_rdata     (inst_rdata),
    .if_valid       (if_valid),
    .if_inst        (if_inst),
    .if_pc          (if_pc),
    .id_allowin     (id_allowin),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef FETCH_PERF_EN
    ,
    .fetch_bubble_cnt (fetch_bubble_cnt)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];
  int    mem_lat = 1;
  bit    mem_rand = 1'b0;

  typedef struct {
    logic [31:0] pc;
    bit          have;
    logic [31:0] data;
  } ment_t;
  ment_t       mdl_q[$];
  bit          m_run;
  logic [31:0] m_pc;
  int          m_drop;
  logic [31:0] m_bub;

  bit          s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_inst, s_bub;

  typedef struct {
    bit          rst_before;
    bit          allow;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
  } vec_t;
  vec_t tab[18];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mdl_q.delete();
    mq.delete();
    m_run  = 1'b0;
    m_pc   = RESET_PC;
    m_drop = 0;
    m_bub  = 32'h0;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    id_allowin     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_addr_ok   = 1'b0;
    inst_data_ok   = 1'b0;
    inst_rdata     = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_inst_req", 32'(inst_req), 32'h0);
    chk("rst_if_valid", 32'(if_valid), 32'h0);
    chk("rst_if_inst", if_inst, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
`ifdef FETCH_PERF_EN
    chk("rst_bubble_cnt", fetch_bubble_cnt, 32'h0);
`endif
    model_reset();
    cyc = 0;
    rst = 1'b0;
  endtask

  task automatic run_cycle(input bit allow, input bit redir, input logic [31:0] rpc,
                           input bit aok);
    bit exp_req, exp_valid, acc, done;
    int pend, lat;
    id_allowin     = allow;
    redirect_valid = redir;
    redirect_pc    = rpc;
    inst_addr_ok   = aok;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      inst_data_ok = 1'b1;
      inst_rdata   = mem_word(mq[0].addr);
    end else begin
      inst_data_ok = 1'b0;
      inst_rdata   = $urandom;
    end
    @(negedge clk);
    s_req   = inst_req;
    s_addr  = inst_addr;
    s_valid = if_valid;
    s_pc    = if_pc;
    s_inst  = if_inst;
`ifdef FETCH_PERF_EN
    s_bub   = fetch_bubble_cnt;
`endif
    exp_req   = m_run && (mdl_q.size() + m_drop < DEPTH) && !redir;
    exp_valid = (mdl_q.size() > 0) && mdl_q[0].have;
    chk("inst_req", 32'(s_req), 32'(exp_req));
    if (exp_req) chk("inst_addr", s_addr, m_pc);
    chk("if_valid", 32'(s_valid), 32'(exp_valid));
    if (exp_valid) begin
      chk("if_pc", s_pc, mdl_q[0].pc);
      chk("if_inst", s_inst, mdl_q[0].data);
      chk("if_inst_vs_mem", s_inst, mem_word(s_pc));
    end else if (mdl_q.size() == 0) begin
      chk("empty_if_pc", s_pc, 32'h0);
      chk("empty_if_inst", s_inst, 32'h0);
    end
`ifdef FETCH_PERF_EN
    chk("bubble_cnt", s_bub, m_bub);
`endif
    acc = s_req && aok;
    if (m_run && allow && !exp_valid && !redir) m_bub = m_bub + 32'd1;
    if (redir) begin
      pend = 0;
      foreach (mdl_q[i]) if (!mdl_q[i].have) pend++;
      m_drop = m_drop + pend - (inst_data_ok ? 1 : 0);
      mdl_q.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (exp_valid && allow) void'(mdl_q.pop_front());
      if (exp_req && aok) begin
        mdl_q.push_back('{m_pc, 1'b0, 32'h0});
        m_pc = m_pc + 32'd4;
      end
      if (inst_data_ok) begin
        if (m_drop > 0) begin
          m_drop--;
        end else begin
          done = 1'b0;
          foreach (mdl_q[i]) begin
            if (!done && !mdl_q[i].have) begin
              mdl_q[i].have = 1'b1;
              mdl_q[i].data = inst_rdata;
              done = 1'b1;
            end
          end
        end
      end
    end
    m_run = 1'b1;
    @(posedge clk);
    if (inst_data_ok) void'(mq.pop_front());
    if (acc) begin
      lat = mem_rand ? int'($urandom_range(1, 4)) : mem_lat;
      mq.push_back('{s_addr, cyc + lat});
    end
    cyc++;
    #1;
  endtask

  task automatic wait_req(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      run_cycle(1'b1, 1'b0, 32'h0, 1'b1);
      ok = s_req;
    end
    if (!ok) chk("wait_req_timeout", 32'(ok), 32'h1);
  endtask

  task automatic wait_valid(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      run_cycle(1'b1, 1'b0, 32'h0, 1'b1);
      ok = s_valid;
    end
    if (!ok) chk("wait_valid_timeout", 32'(ok), 32'h1);
  endtask

  initial begin
    bit ok;
    // Latency-1 memory, always accepting. Rows 0-7 free-running, rows 8-17 stall then release.
    tab[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
    tab[1]  = '{1'b0, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0};
    tab[2]  = '{1'b0, 1'b1, 1'b1, 32'h4,  1'b0, 32'h0};
    tab[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h0};
    tab[4]  = '{1'b0, 1'b1, 1'b1, 32'h8,  1'b1, 32'h4};
    tab[5]  = '{1'b0, 1'b1, 1'b1, 32'hC,  1'b0, 32'h0};
    tab[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h8};
    tab[7]  = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'hC};
    tab[8]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
    tab[9]  = '{1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 32'h0};
    tab[10] = '{1'b0, 1'b0, 1'b1, 32'h4,  1'b0, 32'h0};
    tab[11] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h0};
    tab[12] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h0};
    tab[13] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h0};
    tab[14] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h0};
    tab[15] = '{1'b0, 1'b1, 1'b1, 32'h8,  1'b1, 32'h4};
    tab[16] = '{1'b0, 1'b1, 1'b1, 32'hC,  1'b0, 32'h0};
    tab[17] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h8};

    mem_lat  = 1;
    mem_rand = 1'b0;
    for (int i = 0; i < 18; i++) begin
      if (tab[i].rst_before) do_reset();
      run_cycle(tab[i].allow, 1'b0, 32'h0, 1'b1);
      chk("tab_req", 32'(s_req), 32'(tab[i].e_req));
      if (tab[i].e_req) chk("tab_addr", s_addr, tab[i].e_addr);
      chk("tab_valid", 32'(s_valid), 32'(tab[i].e_valid));
      if (tab[i].e_valid) begin
        chk("tab_pc", s_pc, tab[i].e_pc);
        chk("tab_inst", s_inst, mem_word(tab[i].e_pc));
      end
    end

    // Redirect with two requests in flight.
    do_reset();
    mem_lat = 3;
    repeat (3) run_cycle(1'b1, 1'b0, 32'h0, 1'b1);
    run_cycle(1'b1, 1'b1, 32'h0000_0103, 1'b1);
    wait_req(10, ok);
    if (ok) chk("redir_first_addr", s_addr, 32'h100);
    wait_valid(20, ok);
    if (ok) begin
      chk("redir_first_pc", s_pc, 32'h100);
      chk("redir_first_inst", s_inst, mem_word(32'h100));
    end

    // Redirect together with a data_ok and a head pop.
    do_reset();
    mem_lat = 2;
    repeat (4) run_cycle(1'b1, 1'b0, 32'h0, 1'b1);
    run_cycle(1'b1, 1'b1, 32'h200, 1'b1);
    chk("rdp_head_valid", 32'(s_valid), 32'h1);
    run_cycle(1'b1, 1'b0, 32'h0, 1'b1);
    chk("rdp_req0", 32'(s_req), 32'h1);
    chk("rdp_addr0", s_addr, 32'h200);
    run_cycle(1'b1, 1'b0, 32'h0, 1'b1);
    chk("rdp_req1", 32'(s_req), 32'h1);
    chk("rdp_addr1", s_addr, 32'h204);
    wait_valid(20, ok);
    if (ok) chk("rdp_first_pc", s_pc, 32'h200);

    // PC wrap.
    do_reset();
    mem_lat = 1;
    run_cycle(1'b1, 1'b0, 32'h0, 1'b1);
    run_cycle(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1);
    run_cycle(1'b1, 1'b0, 32'h0, 1'b1);
    chk("wrap_addr0", s_addr, 32'hFFFF_FFFC);
    run_cycle(1'b1, 1'b0, 32'h0, 1'b1);
    chk("wrap_addr1", s_addr, 32'h0000_0000);
    wait_valid(10, ok);
    if (ok) chk("wrap_pc", s_pc, 32'hFFFF_FFFC);
    repeat (6) run_cycle(1'b1, 1'b0, 32'h0, 1'b1);

`ifdef FETCH_PERF_EN
    do_reset();
    mem_lat = 3;
    for (int i = 0; i < 10; i++) begin
      run_cycle(1'b1, 1'b0, 32'h0, 1'b1);
      if (i == 5) begin
        chk("perf_first_valid", 32'(s_valid), 32'h1);
        chk("perf_first_bubbles", s_bub, 32'd4);
      end
    end
`endif

    mem_rand = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if (k % 1000 == 0) do_reset();
      run_cycle($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, $urandom,
                $urandom_range(0, 3) != 0);
    end
    repeat (10) run_cycle(1'b1, 1'b0, 32'h0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
